// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-path constants, store buffer entry type and store legality check
package mem_pkg;
  localparam int SB_ADDR_W = 32;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [2:0]           funct3;
  } sb_entry_t;

  // Only naturally aligned byte, half and word stores are legal
  function automatic logic is_store_legal(input logic [2:0] funct3, input logic [1:0] addr);
    return funct3 == F3_SB || (funct3 == F3_SH && !addr[0]) || (funct3 == F3_SW && addr == 2'b00);
  endfunction
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: core store/load request and memory write port bundle of the store buffer
interface store_buffer_if #(parameter int ADDR_W = 32);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [2:0]        st_funct3;
  logic              st_err;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_funct3;
  logic              empty;

  modport master (
    output st_valid, st_addr, st_data, st_funct3, ld_req, ld_addr,
    input  st_ready, st_err, ld_stall, mem_we, mem_addr, mem_wdata, mem_funct3, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3, ld_req, ld_addr,
    output st_ready, st_err, ld_stall, mem_we, mem_addr, mem_wdata, mem_funct3, empty
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order posted-write FIFO that drains into the memory write port and stalls conflicting loads
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W
) (
  input logic clk,
  input logic rst_n,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sb_entry_t        q [DEPTH];
  sb_entry_t        hd;
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic             illegal, push, pop, hit;

  // Request legality, word-granular conflict search, and drain arbitration against loads
  always_comb begin
    illegal       = sb.st_valid && !is_store_legal(sb.st_funct3, sb.st_addr[1:0]);
    sb.st_err     = illegal;
    sb.st_ready   = count != CW'(DEPTH);
    sb.empty      = count == '0;
    push          = sb.st_valid && sb.st_ready && !illegal;
    hit           = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit || (vld[i] && ADDR_W'(q[i].addr[SB_ADDR_W-1:2]) == ADDR_W'(sb.ld_addr[ADDR_W-1:2]));
    sb.ld_stall   = sb.ld_req && hit;
    pop           = !sb.empty && !(sb.ld_req && !sb.ld_stall);
    hd            = q[head];
    sb.mem_we     = pop;
    sb.mem_addr   = pop ? ADDR_W'(hd.addr) : '0;
    sb.mem_wdata  = pop ? hd.data : '0;
    sb.mem_funct3 = pop ? hd.funct3 : '0;
  end

  // Pointer, occupancy and valid-bit bookkeeping; reset discards every pending store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (pop) begin
        head      <= head + 1'b1;
        vld[head] <= 1'b0;
      end
      if (push) begin
        tail      <= tail + 1'b1;
        vld[tail] <= 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry payload needs no reset since the valid bits qualify it
  always_ff @(posedge clk) begin
    if (push) q[tail] <= '{addr: SB_ADDR_W'(sb.st_addr), data: sb.st_data, funct3: sb.st_funct3};
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer against a queue-based reference model
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  ent_t mq[$];

  store_buffer_if #(.ADDR_W(32)) b();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .sb(b));

  always #5 clk = ~clk;

  function automatic bit legal(logic [2:0] f, logic [31:0] a);
    case (f)
      3'b000:  return 1'b1;
      3'b001:  return a % 2 == 0;
      3'b010:  return a % 4 == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sf,
                       input logic lr, input logic [31:0] la);
    b.st_valid = sv; b.st_addr = sa; b.st_data = sd; b.st_funct3 = sf;
    b.ld_req = lr; b.ld_addr = la;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Compare all outputs against the model at mid-cycle, then advance the model across the edge
  task automatic step();
    bit stall, we, acc;
    ent_t h;
    @(negedge clk);
    stall = 1'b0;
    foreach (mq[i]) if (mq[i].a / 4 == b.ld_addr / 4) stall = b.ld_req;
    we = rst_n && mq.size() != 0 && !(b.ld_req && !stall);
    h = we ? mq[0] : '0;
    chk("empty", 32'(b.empty), 32'(mq.size() == 0));
    chk("st_ready", 32'(b.st_ready), 32'(mq.size() < DEPTH));
    chk("st_err", 32'(b.st_err), 32'(b.st_valid && !legal(b.st_funct3, b.st_addr)));
    chk("ld_stall", 32'(b.ld_stall), 32'(stall));
    chk("mem_we", 32'(b.mem_we), 32'(we));
    chk("mem_addr", b.mem_addr, h.a);
    chk("mem_wdata", b.mem_wdata, h.d);
    chk("mem_funct3", 32'(b.mem_funct3), 32'(h.f));
    acc = rst_n && b.st_valid && mq.size() < DEPTH && legal(b.st_funct3, b.st_addr);
    if (we) void'(mq.pop_front());
    if (acc) mq.push_back('{a: b.st_addr, d: b.st_data, f: b.st_funct3});
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(b.empty), 32'd1);
    chk("rst_ready", 32'(b.st_ready), 32'd1);
    chk("rst_we", 32'(b.mem_we), 32'd0);
    chk("rst_stall", 32'(b.ld_stall), 32'd0);
    chk("rst_err", 32'(b.st_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, '0);
    step();
    idle();
    #1;
    chk("t1_we", 32'(b.mem_we), 32'd1);
    chk("t1_addr", b.mem_addr, 32'h10);
    chk("t1_data", b.mem_wdata, 32'hDEADBEEF);
    chk("t1_f3", 32'(b.mem_funct3), 32'd2);
    step();
    chk("t1_empty", 32'(b.empty), 32'd1);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010, 1'b1, 32'h200);
      step();
    end
    chk("t2_full", 32'(b.st_ready), 32'd0);
    idle();
    repeat (5) step();

    drive(1'b1, 32'h21, 32'h55, 3'b000, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, '0, 1'b1, 32'h22);
    #1;
    chk("t3_stall", 32'(b.ld_stall), 32'd1);
    chk("t3_addr", b.mem_addr, 32'h21);
    step();
    chk("t3_nostall", 32'(b.ld_stall), 32'd0);
    step();

    drive(1'b1, 32'h13, 32'h1, 3'b001, 1'b0, '0);
    #1;
    chk("t4_sh_err", 32'(b.st_err), 32'd1);
    step();
    drive(1'b1, 32'h0, 32'h2, 3'b011, 1'b0, '0);
    #1;
    chk("t4_f3_err", 32'(b.st_err), 32'd1);
    step();
    drive(1'b1, 32'h14, 32'h3, 3'b010, 1'b0, '0);
    step();
    idle();
    repeat (2) step();

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h80 + 32'(4 * i), 32'hB0 + 32'(i), 3'b010, 1'b1, 32'h300);
      step();
    end
    drive(1'b1, 32'h90, 32'hC0, 3'b010, 1'b0, '0);
    #1;
    chk("t5_full_pop_ready", 32'(b.st_ready), 32'd0);
    step();
    drive(1'b1, 32'h90, 32'hC0, 3'b010, 1'b1, 32'h300);
    step();
    chk("t5_refull", 32'(b.st_ready), 32'd0);
    idle();
    repeat (5) step();

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC0 + 32'(4 * i), 32'hD0 + 32'(i), 3'b010, 1'b1, 32'h400);
      step();
    end
    idle();
    rst_n = 1'b0;
    #1;
    chk("t6_we", 32'(b.mem_we), 32'd0);
    chk("t6_empty", 32'(b.empty), 32'd1);
    mq.delete();
    step();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step();

    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      r = $urandom_range(0, 2);
      if (r == 0)
        drive(1'b1, 32'h100 + $urandom_range(0, 31), $urandom,
              ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)), 1'b0, '0);
      else if (r == 1)
        drive(1'b0, '0, '0, '0, 1'b1, 32'h100 + $urandom_range(0, 40));
      else
        idle();
      step();
    end
    idle();
    repeat (DEPTH + 1) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
